// File: rtl/latch_load_seq.sv
// latch_load_seq
//   Loads one word, MSB first, from a serial stream and then presents it to a
//   downstream bank of transparent D-latches. The latch enable is sequenced so
//   that data is stable before the enable opens. Data also stays unchanged for
//   the whole time the enable is open, and for one cycle after it closes.
//
//   Sequence: IDLE -> SHIFT -> SETUP -> STROBE (HOLD cycles) -> RELEASE -> IDLE
//
// Parameters
//   WIDTH     word width in bits (2..32)
//   HOLD      number of cycles En stays high (1..15)
//
// Ports
//   clk       clock; all state changes on its rising edge
//   rst       synchronous active-high reset; takes priority over all inputs
//   start     begin a word load (sampled only in IDLE)
//   sin       serial data bit, MSB first
//   sin_valid sin is valid this cycle (sampled only in SHIFT)
//   D         parallel word to the latch bank (registered)
//   En        latch enable (state decode, high only in STROBE)
//   busy      high in every state except IDLE
//   done      one-cycle pulse in RELEASE when a load completes
module latch_load_seq #(
   parameter int WIDTH = 8,
   parameter int HOLD  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sin,
   input  logic             sin_valid,
   output logic [WIDTH-1:0] D,
   output logic             En,
   output logic             busy,
   output logic             done
);

   // Bit counter reaches WIDTH after the last bit, so it needs to hold WIDTH.
   localparam int CW = $clog2(WIDTH + 1);
   localparam int HW = 4;
   localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      SETUP,
      STROBE,
      RELEASE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [WIDTH-1:0] sr_shifted;

   assign sr_shifted = {sr_q[WIDTH-2:0], sin};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (sin_valid) begin
               sr_d  = sr_shifted;
               cnt_d = cnt_q + 1'b1;
               // The edge that accepts the final bit also publishes the word,
               // so D is already settled during the SETUP cycle.
               if (cnt_q == LAST_BIT) begin
                  d_d     = sr_shifted;
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            state_d = STROBE;
            hold_d  = '0;
         end
         STROBE: begin
            if (hold_q == LAST_HOLD) begin
               state_d = RELEASE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs come only from registers or state decode. Because of this, no
   // input can reach En, busy or done within the same cycle.
   assign D    = d_q;
   assign En   = (state_q == STROBE);
   assign busy = (state_q != IDLE);
   assign done = (state_q == RELEASE);

endmodule

// File: tb/tb_latch_load_seq.sv
// Testbench for latch_load_seq. Instance 0 is WIDTH=8 with HOLD=2. Instance 1
// is WIDTH=4 with HOLD=1. The stimulus pushes the expected word and the
// expected done cycle into a per-instance queue. A monitor per instance
// compares D while En is high. At the done pulse it also compares the word,
// the done cycle and the En length.
module tb_latch_load_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] word;
      int         done_cyc;
   } exp_t;

   exp_t exp_q[2][$];

   logic       rst[2];
   logic       start[2];
   logic       sin[2];
   logic       sinv[2];
   logic [7:0] d_w[2];
   logic       en[2];
   logic       busy[2];
   logic       done[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int W = (gi == 0) ? 8 : 4;
      localparam int H = (gi == 0) ? 2 : 1;
      logic [W-1:0] d;
      int en_len = 0;

      latch_load_seq #(.WIDTH(W), .HOLD(H)) dut (
         .clk      (clk),
         .rst      (rst[gi]),
         .start    (start[gi]),
         .sin      (sin[gi]),
         .sin_valid(sinv[gi]),
         .D        (d),
         .En       (en[gi]),
         .busy     (busy[gi]),
         .done     (done[gi])
      );

      assign d_w[gi] = 8'(d);

      always @(negedge clk) begin
         exp_t e;
         if (en[gi]) begin
            en_len++;
            chk($sformatf("u%0d En/done overlap", gi), 32'(done[gi]), 32'd0);
            if (exp_q[gi].size() != 0)
               chk($sformatf("u%0d D while En", gi), 32'(d_w[gi]), 32'(exp_q[gi][0].word));
         end
         if (done[gi]) begin
            if (exp_q[gi].size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL u%0d unexpected done: got pulse at cycle %0d, expected none", gi, cyc);
            end else begin
               e = exp_q[gi].pop_front();
               chk($sformatf("u%0d D at done", gi), 32'(d_w[gi]), 32'(e.word));
               chk($sformatf("u%0d done cycle", gi), 32'(cyc), 32'(e.done_cyc));
               chk($sformatf("u%0d En length", gi), 32'(en_len), 32'(H));
            end
            en_len = 0;
         end
         if (!busy[gi]) en_len = 0;
      end
   end

   // Drives one load on instance s. The caller is positioned just after a
   // rising edge. done_off is the hand-computed distance of done from the
   // start-accept edge. poke pulses start during SHIFT and during STROBE.
   // abort asserts rst in the first STROBE cycle.
   task automatic load(input int s, input logic [7:0] word, input bit gap,
                       input int done_off, input bit poke, input bit abort);
      int   w;
      int   k;
      int   waited;
      bit   poked;
      exp_t e;
      w = (s == 0) ? 8 : 4;
      k = cyc + 1;
      e.word     = word;
      e.done_cyc = k + done_off;
      exp_q[s].push_back(e);
      start[s] = 1'b1;
      @(posedge clk); #1;
      start[s] = 1'b0;
      for (int i = w - 1; i >= 0; i--) begin
         sin[s]  = word[i];
         sinv[s] = 1'b1;
         if (poke && i == w - 3) start[s] = 1'b1;
         @(posedge clk); #1;
         start[s] = 1'b0;
         if (gap && i > 0) begin
            sinv[s] = 1'b0;
            sin[s]  = ~word[i];
            @(posedge clk); #1;
         end
      end
      sinv[s] = 1'b0;
      waited = 0;
      poked  = 1'b0;
      while (busy[s] && waited < 40) begin
         if (abort && en[s]) begin
            rst[s] = 1'b1;
            exp_q[s].delete();
            @(posedge clk); #1;
            rst[s] = 1'b0;
            chk($sformatf("u%0d abort En", s), 32'(en[s]), 32'd0);
            chk($sformatf("u%0d abort D", s), 32'(d_w[s]), 32'd0);
            chk($sformatf("u%0d abort busy", s), 32'(busy[s]), 32'd0);
            chk($sformatf("u%0d abort done", s), 32'(done[s]), 32'd0);
            return;
         end
         if (poke && en[s] && !poked) begin
            start[s] = 1'b1;
            poked    = 1'b1;
         end else begin
            start[s] = 1'b0;
         end
         @(posedge clk); #1;
         waited++;
      end
      start[s] = 1'b0;
      if (waited >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL u%0d busy timeout: got busy=1 after 40 cycles, expected 0", s);
      end else begin
         chk($sformatf("u%0d idle cycle", s), 32'(cyc), 32'(e.done_cyc + 1));
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         rst[s]   = 1'b1;
         start[s] = 1'b0;
         sin[s]   = 1'b0;
         sinv[s]  = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("u%0d reset D", s), 32'(d_w[s]), 32'd0);
         chk($sformatf("u%0d reset En", s), 32'(en[s]), 32'd0);
         chk($sformatf("u%0d reset busy", s), 32'(busy[s]), 32'd0);
         chk($sformatf("u%0d reset done", s), 32'(done[s]), 32'd0);
         rst[s] = 1'b0;
      end
      // start is accepted on the first edge after reset release
      load(0, 8'hB2, 1'b0, 11, 1'b0, 1'b0);
      load(0, 8'hB2, 1'b1, 18, 1'b0, 1'b0);
      load(0, 8'hFF, 1'b0, 11, 1'b0, 1'b0);
      chk("u0 D holds in IDLE", 32'(d_w[0]), 32'hFF);
      load(0, 8'h00, 1'b0, 11, 1'b0, 1'b0);
      load(0, 8'h5A, 1'b0, 11, 1'b1, 1'b0);
      load(0, 8'hC3, 1'b0, 11, 1'b0, 1'b1);
      load(0, 8'h3C, 1'b0, 11, 1'b0, 1'b0);
      load(1, 8'h0A, 1'b0, 6, 1'b0, 1'b0);
      load(1, 8'h05, 1'b0, 6, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("u0 leftover expected loads", 32'(exp_q[0].size()), 32'd0);
      chk("u1 leftover expected loads", 32'(exp_q[1].size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/latch_load_seq.md
LATCH_LOAD_SEQ -- requirements
Module: latch_load_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter HOLD, default 2, giving the En strobe length in clock cycles (legal range 1..15).
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: the reset, synchronous and active-high.
REQ-005 Port start SHALL be an input, 1 bit: request to begin a word load; sampled only in IDLE.
REQ-006 Port sin SHALL be an input, 1 bit: serial data bit, MSB first.
REQ-007 Port sin_valid SHALL be an input, 1 bit: sin is valid this cycle.
REQ-008 Port D SHALL be an output, WIDTH bits: parallel data to the downstream D-latch bank.
REQ-009 Port En SHALL be an output, 1 bit: latch enable to the downstream D-latch bank.
REQ-010 Port busy SHALL be an output, 1 bit: high in every state except IDLE.
REQ-011 Port done SHALL be an output, 1 bit: one-cycle pulse when a word load completes.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT, SETUP, STROBE and RELEASE, and all outputs SHALL be driven from registers or state decode only, with no combinational path from inputs.
REQ-013 In IDLE, start=1 SHALL move the FSM to SHIFT and clear the bit counter; start=0 SHALL keep it in IDLE.
REQ-014 In SHIFT, each edge with sin_valid=1 SHALL shift sin into the LSB of the shift register (sr <= {sr[WIDTH-2:0], sin}) and increment the counter; sin_valid=0 SHALL hold both sr and the counter.
REQ-015 On the edge that accepts the WIDTH-th bit, the block SHALL load D with the completed word and move to SETUP.
REQ-016 In SETUP, the block SHALL hold En=0 for exactly one cycle so that D is stable before the strobe, then move to STROBE.
REQ-017 In STROBE, the block SHALL hold En=1 for exactly HOLD cycles with D unchanged, then move to RELEASE.
REQ-018 In RELEASE, the block SHALL hold En=0, keep D unchanged and drive done=1 for exactly one cycle, then move to IDLE.
REQ-019 D SHALL change only on the edge entering SETUP, and SHALL hold its last value in IDLE until the next load.
REQ-020 start asserted in any state other than IDLE SHALL be ignored, with no queuing.
REQ-021 sin and sin_valid SHALL be ignored outside SHIFT.
REQ-022 En and done SHALL never be high in the same cycle.
REQ-023 With sin_valid held high, the latency from the start-accept edge k SHALL be as follows:
- SETUP during cycle k+8 (for WIDTH=8);
- En high during cycles k+9 through k+8+HOLD;
- done during cycle k+9+HOLD;
- IDLE after that cycle.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap; it is cleared on entry to SHIFT.

Reset
REQ-025 rst=1 at a rising edge SHALL force the FSM to IDLE and set D=0, sr=0, counter=0, En=0, busy=0 and done=0.
REQ-026 rst SHALL take priority over every other input.
REQ-027 rst asserted mid-STROBE SHALL drop En on that same edge; no done pulse SHALL be produced for the aborted word.
REQ-028 After rst is released, the block SHALL accept start on the first following edge.

Verification
REQ-029 Scenario: WIDTH=8, HOLD=2, start at edge 0, sin_valid=1, sin = 1,0,1,1,0,0,1,0 -> D=8'hB2 from cycle 8, En=1 in cycles 9-10, done=1 in cycle 11, busy=0 from cycle 12.
REQ-030 Scenario: the same word with sin_valid=0 on every second cycle -> D=8'hB2, and SETUP is reached 7 cycles later than in REQ-029.
REQ-031 Scenario: a load of 8'hFF followed by a load of 8'h00 -> D=8'hFF until the second SETUP, then 8'h00; D is never 8'h00 while En=1 during the first load.
REQ-032 Scenario: start pulsed during SHIFT and again during STROBE -> ignored, and exactly one done pulse is produced per accepted start.
REQ-033 Scenario: rst asserted in the first STROBE cycle -> En=0, D=8'h00 and busy=0 at the next cycle, no done pulse; a new start then completes normally.
REQ-034 Scenario: HOLD=1, WIDTH=4, word 4'hA -> En high for exactly 1 cycle, done 1 cycle later, and En and done never overlap.
